// File: rtl/spi_cfg_pkg.sv
// ============================================================================
// spi_cfg_pkg : shared constants and state encoding for spi_cfg_master
// Revision    : 1.0
// ============================================================================
`default_nettype none

package spi_cfg_pkg;

  localparam int         FRAME_BITS   = 16;
  localparam logic       WRITE_BIT    = 1'b1;

  localparam logic [6:0] ADDR_OUT_LO  = 7'h00;
  localparam logic [6:0] ADDR_OUT_HI  = 7'h01;
  localparam logic [6:0] ADDR_PWM_LO  = 7'h02;
  localparam logic [6:0] ADDR_PWM_HI  = 7'h03;
  localparam logic [6:0] ADDR_DUTY    = 7'h04;
  localparam int         NUM_CFG_REGS = 5;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    HIGH  = 3'd2,
    LOW   = 3'd3,
    GAP   = 3'd4
  } state_e;

endpackage

`default_nettype wire

// File: rtl/spi_cfg_rr_arb.sv
// ============================================================================
// spi_cfg_rr_arb : round-robin arbiter, first valid at or after the pointer
// Revision       : 1.0
// ============================================================================
`default_nettype none

module spi_cfg_rr_arb
  import spi_cfg_pkg::*;
#(
  parameter  int NUM_REQ = 2,
  localparam int IDW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] valid_i,
  input  logic [IDW-1:0]     ptr_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [IDW-1:0]     idx_o,
  output logic [IDW-1:0]     nxt_ptr_o,
  output logic               any_o
);

  logic [IDW-1:0] w_cand;
  logic           w_found;

  always_comb begin
    grant_o   = '0;
    idx_o     = '0;
    w_found   = 1'b0;
    w_cand    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_cand = IDW'((int'(ptr_i) + k) % NUM_REQ);
      if (!w_found && valid_i[w_cand]) begin
        w_found         = 1'b1;
        idx_o           = w_cand;
        grant_o[w_cand] = 1'b1;
      end
    end
    nxt_ptr_o = IDW'((int'(idx_o) + 1) % NUM_REQ);
  end

  assign any_o = w_found;

endmodule

`default_nettype wire

// File: rtl/spi_cfg_master.sv
// ============================================================================
// spi_cfg_master : SPI mode-0 register-write sequencer with round-robin intake
// Optional build macro SPI_CFG_SHADOW_EN adds shadow_regs mirror output.
// Revision       : 1.0
// ============================================================================
`default_nettype none

module spi_cfg_master
  import spi_cfg_pkg::*;
#(
  parameter  int NUM_REQ    = 2,
  parameter  int CLK_DIV    = 4,
  parameter  int GAP_CYCLES = 8,
  localparam int IDW        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [7*NUM_REQ-1:0]   req_addr,
  input  logic [8*NUM_REQ-1:0]   req_data,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic                   sclk,
  output logic                   ncs,
  output logic                   copi,
  output logic                   busy,
  output logic                   done,
  output logic [IDW-1:0]         done_id
`ifdef SPI_CFG_SHADOW_EN
  ,
  output logic [8*NUM_CFG_REGS-1:0] shadow_regs
`endif
);

  localparam int CNT_MAX = (CLK_DIV > GAP_CYCLES) ? CLK_DIV : GAP_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);

  state_e                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [4:0]              bit_q, bit_d;
  logic [FRAME_BITS-1:0]   shift_q, shift_d;
  logic [IDW-1:0]          ptr_q, ptr_d;
  logic [IDW-1:0]          id_q, id_d;
  logic                    sclk_q, sclk_d;
  logic                    ncs_q, ncs_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic [NUM_REQ-1:0]      ready_q, ready_d;

  logic [NUM_REQ-1:0]      w_grant;
  logic [IDW-1:0]          w_idx;
  logic [IDW-1:0]          w_nxt_ptr;
  logic                    w_any;
  logic                    w_phase_end;
  logic [6:0]              w_addr;
  logic [7:0]              w_data;

  spi_cfg_rr_arb #(.NUM_REQ(NUM_REQ)) u_arb (
    .valid_i   (req_valid),
    .ptr_i     (ptr_q),
    .grant_o   (w_grant),
    .idx_o     (w_idx),
    .nxt_ptr_o (w_nxt_ptr),
    .any_o     (w_any)
  );

  assign w_addr      = req_addr[7*w_idx +: 7];
  assign w_data      = req_data[8*w_idx +: 8];
  assign w_phase_end = (cnt_q == CW'(CLK_DIV - 1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    ptr_d   = ptr_q;
    id_d    = id_q;
    sclk_d  = sclk_q;
    ncs_d   = ncs_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    ready_d = '0;

    case (state_q)
      IDLE: begin
        if (w_any) begin
          ready_d = w_grant;
          id_d    = w_idx;
          ptr_d   = w_nxt_ptr;
          shift_d = {WRITE_BIT, w_addr, w_data};
          ncs_d   = 1'b0;
          busy_d  = 1'b1;
          cnt_d   = '0;
          bit_d   = '0;
          state_d = SETUP;
        end
      end
      SETUP: begin
        if (w_phase_end) begin
          cnt_d   = '0;
          sclk_d  = 1'b1;
          state_d = HIGH;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      HIGH: begin
        // Falling edge: shifting left presents the next bit; after the last
        // bit the register is all zeros, which parks copi low.
        if (w_phase_end) begin
          cnt_d   = '0;
          sclk_d  = 1'b0;
          bit_d   = bit_q + 5'd1;
          shift_d = {shift_q[FRAME_BITS-2:0], 1'b0};
          state_d = LOW;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      LOW: begin
        if (w_phase_end) begin
          cnt_d = '0;
          if (bit_q == 5'(FRAME_BITS)) begin
            ncs_d   = 1'b1;
            done_d  = 1'b1;
            state_d = GAP;
          end else begin
            sclk_d  = 1'b1;
            state_d = HIGH;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      GAP: begin
        if (cnt_q == CW'(GAP_CYCLES - 1)) begin
          cnt_d   = '0;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      ptr_q   <= '0;
      id_q    <= '0;
      sclk_q  <= 1'b0;
      ncs_q   <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ready_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      sclk_q  <= sclk_d;
      ncs_q   <= ncs_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ready_q <= ready_d;
    end
  end

  assign req_ready = ready_q;
  assign sclk      = sclk_q;
  assign ncs       = ncs_q;
  assign copi      = shift_q[FRAME_BITS-1];
  assign busy      = busy_q;
  assign done      = done_q;
  assign done_id   = id_q;

`ifdef SPI_CFG_SHADOW_EN
  logic [FRAME_BITS-1:0] frame_q;
  logic [7:0]            shadow_q [NUM_CFG_REGS];

  // Mirrors commit on the same edge that raises done, so they agree with it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_q <= '0;
      for (int k = 0; k < NUM_CFG_REGS; k++) begin
        shadow_q[k] <= '0;
      end
    end else begin
      if (state_q == IDLE && w_any) begin
        frame_q <= {WRITE_BIT, w_addr, w_data};
      end
      if (done_d) begin
        for (int k = 0; k < NUM_CFG_REGS; k++) begin
          if (frame_q[14:8] == 7'(k)) begin
            shadow_q[k] <= frame_q[7:0];
          end
        end
      end
    end
  end

  for (genvar k = 0; k < NUM_CFG_REGS; k++) begin : g_shadow_out
    assign shadow_regs[8*k +: 8] = shadow_q[k];
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_spi_cfg_master.sv
// ============================================================================
// tb_spi_cfg_master : scoreboard bench with SPI peripheral model for spi_cfg_master
// Revision          : 1.0
// ============================================================================
`default_nettype none

module tb_spi_cfg_master;
  import spi_cfg_pkg::*;

  localparam int NUM_REQ     = 2;
  localparam int CLK_DIV     = 4;
  localparam int GAP_CYCLES  = 8;
  localparam int IDW         = $clog2(NUM_REQ);
  localparam int FRAME_LOW   = 33 * CLK_DIV;
  localparam int ACC_SPACING = 33 * CLK_DIV + GAP_CYCLES + 1;

  typedef struct {
    int         id;
    logic [6:0] addr;
    logic [7:0] data;
  } exp_t;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 v  [NUM_REQ];
  logic [6:0]           ta [NUM_REQ];
  logic [7:0]           td [NUM_REQ];
  logic [NUM_REQ-1:0]   req_valid;
  logic [7*NUM_REQ-1:0] req_addr;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_ready;
  logic                 sclk, ncs, copi, busy, done;
  logic [IDW-1:0]       done_id;
`ifdef SPI_CFG_SHADOW_EN
  logic [8*NUM_CFG_REGS-1:0] shadow_regs;
`endif

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_pack
    assign req_valid[i]        = v[i];
    assign req_addr[7*i +: 7]  = ta[i];
    assign req_data[8*i +: 8]  = td[i];
  end

  spi_cfg_master #(
    .NUM_REQ    (NUM_REQ),
    .CLK_DIV    (CLK_DIV),
    .GAP_CYCLES (GAP_CYCLES)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .req_ready (req_ready),
    .sclk      (sclk),
    .ncs       (ncs),
    .copi      (copi),
    .busy      (busy),
    .done      (done),
    .done_id   (done_id)
`ifdef SPI_CFG_SHADOW_EN
    ,
    .shadow_regs (shadow_regs)
`endif
  );

  always #5 clk = ~clk;

  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc   = 0;
  int   ptr_m = 0;
  int   n_done = 0;
  int   stray = 0;
  exp_t sbq [$];
  logic [7:0] peri     [NUM_CFG_REGS];
  logic [7:0] shadow_m [NUM_CFG_REGS];

  // Serial-side monitor state
  logic [15:0] fr_m;
  int          bits_m, low_cnt, gap_cnt;
  logic        ncs_p, sclk_p, gap_known;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [8*NUM_CFG_REGS-1:0] pack_regs(input logic [7:0] a [NUM_CFG_REGS]);
    logic [8*NUM_CFG_REGS-1:0] r;
    r = '0;
    for (int k = 0; k < NUM_CFG_REGS; k++) r[8*k +: 8] = a[k];
    return r;
  endfunction

  // Expected service order for requests presented together while idle.
  task automatic model_push(input logic [NUM_REQ-1:0] mask);
    logic [NUM_REQ-1:0] rem;
    int c;
    bit hit;
    rem = mask;
    while (rem != 0) begin
      hit = 1'b0;
      for (int k = 0; k < NUM_REQ; k++) begin
        c = (ptr_m + k) % NUM_REQ;
        if (!hit && rem[c]) begin
          hit = 1'b1;
          sbq.push_back('{id: c, addr: ta[c], data: td[c]});
          rem[c] = 1'b0;
          ptr_m  = (c + 1) % NUM_REQ;
        end
      end
    end
  endtask

  task automatic send(input int i);
    int n;
    @(negedge clk);
    v[i] = 1'b1;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!req_ready[i] && n < 2000);
    if (!req_ready[i]) check($sformatf("ready_timeout_p%0d", i), 0, 1);
    @(posedge clk); #1;
    v[i] = 1'b0;
    check($sformatf("ready_pulse_p%0d", i), req_ready[i], 0);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((sbq.size() != 0 || busy) && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    check("idle_reached", (sbq.size() == 0 && !busy), 1);
  endtask

  initial begin
    ncs_p = 1'b1; sclk_p = 1'b0; gap_known = 1'b0;
    fr_m = '0; bits_m = 0; low_cnt = 0; gap_cnt = 0;
    for (int k = 0; k < NUM_CFG_REGS; k++) begin peri[k] = '0; shadow_m[k] = '0; end
    forever begin
      @(negedge clk);
      if (rst) begin
        gap_known = 1'b0; ncs_p = 1'b1; sclk_p = 1'b0;
        bits_m = 0; low_cnt = 0;
        for (int k = 0; k < NUM_CFG_REGS; k++) begin peri[k] = '0; shadow_m[k] = '0; end
      end else begin
        if (!ncs && ncs_p) begin
          if (gap_known) check("ncs_gap_min", gap_cnt >= GAP_CYCLES, 1);
          bits_m = 0; low_cnt = 0; fr_m = '0;
        end
        if (ncs && !ncs_p) begin
          gap_cnt = 0;
          if (bits_m == 16 && fr_m[15] && fr_m[14:8] < 7'(NUM_CFG_REGS))
            peri[fr_m[14:8]] = fr_m[7:0];
        end
        if (!ncs) low_cnt++; else gap_cnt++;
        if (!ncs && sclk && !sclk_p) begin
          fr_m = {fr_m[14:0], copi};
          bits_m++;
        end
        if (ncs && sclk) stray++;
        if (req_ready != 0) begin
          if (sbq.size() == 0) check("ready_unexpected", req_ready, 0);
          else check("ready_grant", req_ready, 1 << sbq[0].id);
        end
        if (done) begin
          exp_t e;
          n_done++;
          if (sbq.size() == 0) begin
            check("done_unexpected", 1, 0);
          end else begin
            e = sbq.pop_front();
            check("done_id", done_id, e.id);
            check("frame", fr_m, {1'b1, e.addr, e.data});
            check("bit_count", bits_m, 16);
            check("ncs_low_cycles", low_cnt, FRAME_LOW);
            if (e.addr < 7'(NUM_CFG_REGS)) shadow_m[e.addr] = e.data;
`ifdef SPI_CFG_SHADOW_EN
            check("shadow_on_done", shadow_regs, pack_regs(shadow_m));
`endif
          end
          gap_known = 1'b1;
        end
        ncs_p  = ncs;
        sclk_p = sclk;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, t1, nd;
    for (int i = 0; i < NUM_REQ; i++) begin v[i] = 1'b0; ta[i] = '0; td[i] = '0; end
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ncs", ncs, 1);
    check("rst_sclk", sclk, 0);
    check("rst_copi", copi, 0);
    check("rst_ready", req_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_done_id", done_id, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(posedge clk);

    // Single write to the duty register
    ta[0] = 7'h04; td[0] = 8'hA5;
    model_push(2'b01);
    send(0);
    check("busy_after_accept", busy, 1);
    wait_idle();
    check("peri_duty", peri[4], 8'hA5);

    // Two requesters held together, two rounds
    repeat (2) begin
      ta[0] = 7'h00; td[0] = 8'h12;
      ta[1] = 7'h01; td[1] = 8'h34;
      model_push(2'b11);
      fork
        send(0);
        send(1);
      join
      wait_idle();
    end
    check("peri_out_lo", peri[0], 8'h12);
    check("peri_out_hi", peri[1], 8'h34);

    // Back-to-back on one port
    ta[1] = 7'h02; td[1] = 8'h3C;
    model_push(2'b10);
    send(1);
    t0 = cyc;
    ta[1] = 7'h03; td[1] = 8'hC3;
    model_push(2'b10);
    send(1);
    t1 = cyc;
    check("accept_spacing", t1 - t0, ACC_SPACING);
    wait_idle();

    // Out-of-range address leaves the register file alone
    ta[0] = 7'h7F; td[0] = 8'hFF;
    model_push(2'b01);
    send(0);
    wait_idle();
    check("peri_unchanged", pack_regs(peri), 40'hA5_C3_3C_34_12);

    // Reset in the middle of a frame
    ta[0] = 7'h05; td[0] = 8'h99;
    model_push(2'b01);
    send(0);
    begin
      int n;
      n = 0;
      while (bits_m < 7 && n < 1000) begin @(posedge clk); n++; end
    end
    check("reached_bit7", bits_m >= 7, 1);
    check("ncs_low_before_rst", ncs, 0);
    nd = n_done;
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_ncs", ncs, 1);
    check("async_rst_sclk", sclk, 0);
    sbq.delete();
    ptr_m = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check("no_done_after_rst", n_done, nd);
    check("idle_after_rst", busy, 0);

    ta[0] = 7'h03; td[0] = 8'h5A;
    model_push(2'b01);
    send(0);
    wait_idle();
    check("peri_pwm_hi", peri[3], 8'h5A);

    ta[1] = 7'h06; td[1] = 8'h11;
    model_push(2'b10);
    send(1);
    wait_idle();
`ifdef SPI_CFG_SHADOW_EN
    check("shadow_final", shadow_regs, 40'h00_5A_00_00_00);
`endif
    check("sclk_while_ncs_high", stray, 0);
    check("scoreboard_empty", sbq.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
